// File: rtl/param_sync_fifo_pkg.sv
// Shared types, defaults and helpers for the parametrised sync FIFO.
// Optional first-word fall-through build: define FIFO_FWFT_EN.
package fifo_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_AFULL  = 12;
  localparam int DEF_AEMPTY = 4;

  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Pointers carry a wrap bit; the masked difference is the occupancy.
  function automatic logic [31:0] fifo_level(
    input logic [31:0] wp,
    input logic [31:0] rp,
    input int          pw
  );
    logic [31:0] m;
    m = (32'd1 << pw) - 32'd1;
    return (wp - rp) & m;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Request/response bundle between a FIFO user and the FIFO.
// Shared by default and FIFO_FWFT_EN builds.
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int AW = clog2_f(DEPTH);

  logic             clr;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      level;
  logic             overflow;
  logic             underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty,
    input  almost_full, almost_empty, level,
    input  overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty,
    output almost_full, almost_empty, level,
    output overflow, underflow
  );

endinterface

// File: rtl/param_sync_fifo_ram.sv
// Simple dual-port storage; read port is async under FIFO_FWFT_EN,
// registered (with reset) otherwise.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2_f(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  logic [WIDTH-1:0] rdata_q;

  // Reads old contents when a full-FIFO write hits the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO: pointers, accept logic, registered level/flags.
// Define FIFO_FWFT_EN for first-word fall-through reads.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int AFULL_THRESH  = DEF_AFULL,
  parameter int AEMPTY_THRESH = DEF_AEMPTY
) (
  input logic              clk,
  input logic              reset_n,
  param_sync_fifo_if.slave bus
);

  localparam int AW = clog2_f(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [AW:0] LVL_FULL = PW'(DEPTH);
  localparam logic [AW:0] LVL_AF   = PW'(AFULL_THRESH);
  localparam logic [AW:0] LVL_AE   = PW'(AEMPTY_THRESH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        afull_q, afull_d;
  logic        aempty_q, aempty_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic        rd_acc, wr_acc;
  logic        rd_go, wr_go;
  logic [WIDTH-1:0] ram_rdata;

  always_comb begin
    rd_acc = bus.rd_en & ~empty_q;
    wr_acc = bus.wr_en & (~full_q | rd_acc);
    rd_go  = rd_acc & ~bus.clr;
    wr_go  = wr_acc & ~bus.clr;

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_go};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_go};
    ovf_d    = ovf_q | (bus.wr_en & ~wr_acc);
    unf_d    = unf_q | (bus.rd_en & ~rd_acc);

    // Flush wins over any same-cycle request and its error.
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end

    level_d  = PW'(fifo_level(32'(wr_ptr_d), 32'(rd_ptr_d), PW));
    full_d   = (level_d == LVL_FULL);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= LVL_AF);
    aempty_d = (level_d <= LVL_AE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .rst_n(reset_n),
    .we   (wr_go),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(bus.wr_data),
    .re   (rd_go),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(ram_rdata)
  );

`ifdef FIFO_FWFT_EN
  assign bus.rd_data  = empty_q ? '0 : ram_rdata;
  assign bus.rd_valid = ~empty_q;
`else
  logic rd_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_valid_q <= 1'b0;
    else rd_valid_q <= rd_go;
  end

  assign bus.rd_data  = ram_rdata;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (DEPTH=16, WIDTH=8).
// Covers default and FIFO_FWFT_EN builds.
module tb_param_sync_fifo;
  import fifo_pkg::*;

  localparam int W = 8;
  localparam int D = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  param_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  param_sync_fifo #(
    .WIDTH(W), .DEPTH(D),
    .AFULL_THRESH(12), .AEMPTY_THRESH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  // {full, empty, almost_full, almost_empty, overflow, underflow}
  function automatic logic [5:0] flg();
    return {bus.full, bus.empty, bus.almost_full,
            bus.almost_empty, bus.overflow, bus.underflow};
  endfunction

  task automatic cyc(input logic w, input logic [7:0] d,
                     input logic r, input logic c);
    bus.wr_en = w;
    bus.wr_data = d;
    bus.rd_en = r;
    bus.clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pop(output logic [7:0] d, output logic v);
`ifdef FIFO_FWFT_EN
    d = bus.rd_data;
    v = bus.rd_valid;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
`else
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    d = bus.rd_data;
    v = bus.rd_valid;
`endif
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.rd_en = 0; bus.clr = 0; bus.wr_data = 0;
    reset_n = 1'b0;
    #12;
    checks++; if (flg() !== 6'b010100) begin failures++; $display("FAIL reset_flags: got %b want %b", flg(), 6'b010100); end
    checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
    reset_n = 1'b1;
    repeat (3) cyc(0, 8'h00, 0, 0);
    checks++; if (flg() !== 6'b010100) begin failures++; $display("FAIL idle_flags: got %b want %b", flg(), 6'b010100); end
    checks++; if (bus.level !== 5'd0 || bus.rd_valid !== 1'b0) begin failures++; $display("FAIL idle_level_valid: got %0d/%b want 0/0", bus.level, bus.rd_valid); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] d;
    logic v;
    logic [5:0] ef;
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      ef = {i == 16, 1'b0, i >= 12, i <= 4, 2'b00};
      checks++; if (bus.level !== 5'(i)) begin failures++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, bus.level, i); end
      checks++; if (flg() !== ef) begin failures++; $display("FAIL fill_flags[%0d]: got %b want %b", i, flg(), ef); end
    end
    for (int i = 1; i <= 16; i++) begin
      pop(d, v);
      ef = {1'b0, i == 16, (16 - i) >= 12, (16 - i) <= 4, 2'b00};
      checks++; if (d !== 8'(i) || v !== 1'b1) begin failures++; $display("FAIL drain_data[%0d]: got %h/%b want %h/1", i, d, v, 8'(i)); end
      checks++; if (bus.level !== 5'(16 - i)) begin failures++; $display("FAIL drain_level[%0d]: got %0d want %0d", i, bus.level, 16 - i); end
      checks++; if (flg() !== ef) begin failures++; $display("FAIL drain_flags[%0d]: got %b want %b", i, flg(), ef); end
    end
    cyc(0, 8'h00, 0, 0);
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL drain_valid_drop: got %b want 0", bus.rd_valid); end
`ifndef FIFO_FWFT_EN
    checks++; if (bus.rd_data !== 8'h10) begin failures++; $display("FAIL drain_data_hold: got %h want 10", bus.rd_data); end
`endif
  endtask

  task automatic test_full_wr_rd();
    logic [7:0] d;
    logic v;
    for (int i = 1; i <= 16; i++) cyc(1, 8'(i), 0, 0);
`ifdef FIFO_FWFT_EN
    checks++; if (bus.rd_data !== 8'h01) begin failures++; $display("FAIL full_head: got %h want 01", bus.rd_data); end
`endif
    cyc(1, 8'hAA, 1, 0);
    checks++; if (bus.level !== 5'd16 || bus.full !== 1'b1) begin failures++; $display("FAIL full_wr_rd_level: got %0d/%b want 16/1", bus.level, bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL full_wr_rd_ovf: got %b want 0", bus.overflow); end
`ifndef FIFO_FWFT_EN
    checks++; if (bus.rd_data !== 8'h01 || bus.rd_valid !== 1'b1) begin failures++; $display("FAIL full_wr_rd_data: got %h/%b want 01/1", bus.rd_data, bus.rd_valid); end
`endif
    cyc(1, 8'hBB, 0, 0);
    checks++; if (bus.overflow !== 1'b1 || bus.level !== 5'd16) begin failures++; $display("FAIL overflow_set: got %b/%0d want 1/16", bus.overflow, bus.level); end
    for (int i = 2; i <= 16; i++) begin
      pop(d, v);
      checks++; if (d !== 8'(i) || v !== 1'b1) begin failures++; $display("FAIL full_drain[%0d]: got %h/%b want %h/1", i, d, v, 8'(i)); end
    end
    pop(d, v);
    checks++; if (d !== 8'hAA || v !== 1'b1) begin failures++; $display("FAIL full_last_aa: got %h/%b want aa/1", d, v); end
    checks++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin failures++; $display("FAIL full_end_state: got %b/%b want 1/1", bus.empty, bus.overflow); end
    cyc(0, 8'h00, 0, 1);
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL clr_ovf: got %b want 0", bus.overflow); end
  endtask

  task automatic test_empty_wr_rd();
    logic [7:0] d;
    logic v;
    cyc(1, 8'h55, 1, 0);
    checks++; if (bus.underflow !== 1'b1 || bus.level !== 5'd1) begin failures++; $display("FAIL empty_wr_rd: got %b/%0d want 1/1", bus.underflow, bus.level); end
`ifndef FIFO_FWFT_EN
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL empty_wr_rd_valid: got %b want 0", bus.rd_valid); end
`endif
    pop(d, v);
    checks++; if (d !== 8'h55 || v !== 1'b1) begin failures++; $display("FAIL empty_read_55: got %h/%b want 55/1", d, v); end
    checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL empty_after: got %0d/%b want 0/1", bus.level, bus.empty); end
    cyc(0, 8'h00, 0, 1);
    checks++; if (bus.underflow !== 1'b0) begin failures++; $display("FAIL clr_unf: got %b want 0", bus.underflow); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] wv;
    logic [7:0] popped;
    logic w, r, racc, wacc;
    wv = 8'h80;
    popped = 8'h00;
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int ph = 0; ph < 2; ph++) begin
        for (int k = 0; k < 20; k++) begin
          w = (ph == 0) ? 1'b1 : (k % 3 == 0);
          r = (ph == 0) ? (k % 3 == 0) : 1'b1;
`ifdef FIFO_FWFT_EN
          if (q.size() != 0) begin
            checks++; if (bus.rd_data !== q[0] || bus.rd_valid !== 1'b1) begin failures++; $display("FAIL wrap_head r%0d p%0d k%0d: got %h want %h", rnd, ph, k, bus.rd_data, q[0]); end
          end
`endif
          racc = r && (q.size() != 0);
          wacc = w && ((q.size() != D) || racc);
          cyc(w, wv, r, 0);
          if (racc) popped = q.pop_front();
          if (wacc) q.push_back(wv);
          wv = wv + 8'd1;
          checks++; if (bus.level !== 5'(q.size())) begin failures++; $display("FAIL wrap_level r%0d p%0d k%0d: got %0d want %0d", rnd, ph, k, bus.level, q.size()); end
`ifndef FIFO_FWFT_EN
          checks++; if (bus.rd_valid !== racc || (racc && bus.rd_data !== popped)) begin failures++; $display("FAIL wrap_data r%0d p%0d k%0d: got %h/%b want %h/%b", rnd, ph, k, bus.rd_data, bus.rd_valid, popped, racc); end
`endif
        end
      end
    end
    cyc(0, 8'h00, 0, 1);
    checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL wrap_clr: got %0d/%b want 0/1", bus.level, bus.empty); end
  endtask

  task automatic test_clr();
    logic [7:0] held;
    logic [7:0] d;
    logic v;
    cyc(0, 8'h00, 1, 0);
    checks++; if (bus.underflow !== 1'b1) begin failures++; $display("FAIL clr_pre_unf: got %b want 1", bus.underflow); end
    held = bus.rd_data;
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    checks++; if (bus.level !== 5'd9) begin failures++; $display("FAIL clr_pre_level: got %0d want 9", bus.level); end
    cyc(1, 8'h77, 1, 1);
    checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL clr_level: got %0d want 0", bus.level); end
    checks++; if (flg() !== 6'b010100) begin failures++; $display("FAIL clr_flags: got %b want %b", flg(), 6'b010100); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL clr_rd_valid: got %b want 0", bus.rd_valid); end
`ifndef FIFO_FWFT_EN
    checks++; if (bus.rd_data !== held) begin failures++; $display("FAIL clr_rd_hold: got %h want %h", bus.rd_data, held); end
`endif
    cyc(1, 8'h3C, 0, 0);
`ifdef FIFO_FWFT_EN
    checks++; if (bus.rd_data !== 8'h3C || bus.rd_valid !== 1'b1) begin failures++; $display("FAIL fwft_fallthrough: got %h/%b want 3c/1", bus.rd_data, bus.rd_valid); end
`endif
    pop(d, v);
    checks++; if (d !== 8'h3C || v !== 1'b1) begin failures++; $display("FAIL clr_then_write: got %h/%b want 3c/1", d, v); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h90 + i), 0, 0);
    cyc(0, 8'h00, 1, 0);
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.level !== 5'd0 || flg() !== 6'b010100) begin failures++; $display("FAIL async_reset: got %0d/%b want 0/%b", bus.level, flg(), 6'b010100); end
    checks++; if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0) begin failures++; $display("FAIL async_reset_rd: got %h/%b want 00/0", bus.rd_data, bus.rd_valid); end
    #10;
    reset_n = 1'b1;
    cyc(0, 8'h00, 0, 0);
    checks++; if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin failures++; $display("FAIL post_reset: got %b/%0d want 1/0", bus.empty, bus.level); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_wr_rd();
    test_empty_wr_rd();
    test_wrap();
    test_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
